// File: rtl/clk_div_gen.sv
// Multi-channel programmable clock divider / clock-enable generator with glitch-free reconfig.
// Optional global realign input sync_in is built when CLK_DIV_SYNC_EN is defined.
module clk_div_gen #(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned CH_W    = 2,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned DIV_RST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic [CNT_W-1:0]  cfg_phase,
`ifdef CLK_DIV_SYNC_EN
    input  logic              sync_in,
`endif
    output logic              cfg_ready,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] clk_en,
    output logic [NUM_CH-1:0] locked
);

    localparam logic [0:0] ST_HOLD = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO = CNT_W'(2);

    logic [NUM_CH-1:0] pend;
    logic [CNT_W-1:0]  div_clamped;

    assign div_clamped = (cfg_div < TWO) ? TWO : cfg_div;

    always_comb begin
        cfg_ready = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_ch == CH_W'(i)) begin
                cfg_ready = ~pend[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [CNT_W-1:0] div_q, div_d, phase_q, phase_d;
        logic [CNT_W-1:0] sh_div_q, sh_div_d, sh_phase_q, sh_phase_d;
        logic [CNT_W-1:0] cnt_q, cnt_d, hold_q, hold_d;
        logic [0:0]       state_q, state_d;
        logic             pend_q, pend_d;
        logic             out_q, out_d, en_q, en_d, lock_q, lock_d;
        logic             wr;

        // cfg_ready already covers both the range check and the pending flag
        assign wr = cfg_we & cfg_ready & (cfg_ch == CH_W'(g));

        always_comb begin
            div_d      = div_q;
            phase_d    = phase_q;
            sh_div_d   = sh_div_q;
            sh_phase_d = sh_phase_q;
            pend_d     = pend_q;
            cnt_d      = cnt_q;
            hold_d     = hold_q;
            state_d    = state_q;

            if (state_q == ST_HOLD) begin
                if (hold_q <= ONE) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_q - ONE;
                end
            end else begin
                if (cnt_q >= div_q - ONE) begin
                    cnt_d = '0;
                    // Only a shadow pending before this boundary cycle may commit here
                    if (pend_q) begin
                        div_d   = sh_div_q;
                        phase_d = sh_phase_q;
                        pend_d  = 1'b0;
                        if (sh_phase_q != '0) begin
                            state_d = ST_HOLD;
                            hold_d  = sh_phase_q;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end

`ifdef CLK_DIV_SYNC_EN
            if (sync_in) begin
                if (pend_q) begin
                    div_d   = sh_div_q;
                    phase_d = sh_phase_q;
                end
                pend_d  = 1'b0;
                state_d = ST_HOLD;
                cnt_d   = '0;
                hold_d  = pend_q ? sh_phase_q : phase_q;
            end
`endif

            if (wr) begin
                sh_div_d   = div_clamped;
                sh_phase_d = cfg_phase;
                pend_d     = 1'b1;
            end

            // Outputs are computed from next state so they line up with the cnt they describe
            out_d  = (state_d == ST_RUN) && (cnt_d < (div_d >> 1));
            en_d   = (state_d == ST_RUN) && (cnt_d == '0);
            lock_d = (state_d == ST_RUN) && !pend_d;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                div_q      <= CNT_W'(DIV_RST);
                phase_q    <= '0;
                sh_div_q   <= CNT_W'(DIV_RST);
                sh_phase_q <= '0;
                pend_q     <= 1'b0;
                cnt_q      <= '0;
                hold_q     <= '0;
                state_q    <= ST_HOLD;
                out_q      <= 1'b0;
                en_q       <= 1'b0;
                lock_q     <= 1'b0;
            end else begin
                div_q      <= div_d;
                phase_q    <= phase_d;
                sh_div_q   <= sh_div_d;
                sh_phase_q <= sh_phase_d;
                pend_q     <= pend_d;
                cnt_q      <= cnt_d;
                hold_q     <= hold_d;
                state_q    <= state_d;
                out_q      <= out_d;
                en_q       <= en_d;
                lock_q     <= lock_d;
            end
        end

        assign pend[g]    = pend_q;
        assign clk_out[g] = out_q;
        assign clk_en[g]  = en_q;
        assign locked[g]  = lock_q;
    end

endmodule

// File: tb/tb_clk_div_gen.sv
// Randomized bench for clk_div_gen against a period-queue waveform model.
// Exercises sync_in as well when CLK_DIV_SYNC_EN is defined.
module tb_clk_div_gen;
    localparam int NUM_CH  = 4;
    localparam int CH_W    = 2;
    localparam int CNT_W   = 16;
    localparam int DIV_RST = 4;
    localparam int N_CYC   = 3000;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cfg_we = 1'b0;
    logic [CH_W-1:0]   cfg_ch = '0;
    logic [CNT_W-1:0]  cfg_div = '0;
    logic [CNT_W-1:0]  cfg_phase = '0;
    logic              sync_in = 1'b0;
    logic              cfg_ready;
    logic [NUM_CH-1:0] clk_out, clk_en, locked;

    clk_div_gen #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W),
        .CNT_W  (CNT_W),
        .DIV_RST(DIV_RST)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cfg_we   (cfg_we),
        .cfg_ch   (cfg_ch),
        .cfg_div  (cfg_div),
        .cfg_phase(cfg_phase),
`ifdef CLK_DIV_SYNC_EN
        .sync_in  (sync_in),
`endif
        .cfg_ready(cfg_ready),
        .clk_out  (clk_out),
        .clk_en   (clk_en),
        .locked   (locked)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model: each channel holds a queue of upcoming output cycles {run, out, en}
    logic [2:0] mq [NUM_CH][$];
    int m_div [NUM_CH], m_phase [NUM_CH], m_sdiv [NUM_CH], m_sphase [NUM_CH];
    bit m_pend [NUM_CH];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_period(input int c, input int d);
        for (int k = 0; k < d; k++) mq[c].push_back({1'b1, (k < d / 2), (k == 0)});
    endtask

    task automatic push_hold(input int c, input int n);
        for (int k = 0; k < n; k++) mq[c].push_back(3'b000);
    endtask

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            mq[c].delete();
            m_div[c] = DIV_RST; m_phase[c] = 0; m_sdiv[c] = DIV_RST; m_sphase[c] = 0;
            m_pend[c] = 0;
            push_hold(c, 1);
            push_period(c, DIV_RST);
        end
    endtask

    task automatic apply_shadow(input int c);
        m_div[c] = m_sdiv[c];
        m_phase[c] = m_sphase[c];
        m_pend[c] = 0;
    endtask

    // Advance one clock edge given the inputs presented in the cycle that just ended
    task automatic model_tick(input bit we, input int ch, input int dv, input int ph, input bit sy);
        bit acc;
        acc = we && (ch < NUM_CH) && !m_pend[ch];
        for (int c = 0; c < NUM_CH; c++) begin
            if (sy) begin
                if (m_pend[c]) apply_shadow(c);
                mq[c].delete();
                push_hold(c, (m_phase[c] > 0) ? m_phase[c] : 1);
                push_period(c, m_div[c]);
            end else if (mq[c].size() == 1) begin
                void'(mq[c].pop_front());
                if (m_pend[c]) begin
                    apply_shadow(c);
                    push_hold(c, m_phase[c]);
                end
                push_period(c, m_div[c]);
            end else begin
                void'(mq[c].pop_front());
            end
        end
        if (acc) begin
            m_sdiv[ch] = (dv < 2) ? 2 : dv;
            m_sphase[ch] = ph;
            m_pend[ch] = 1;
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [NUM_CH-1:0] eo, ee, el;
        logic [2:0] e;
        for (int c = 0; c < NUM_CH; c++) begin
            e = mq[c][0];
            eo[c] = e[1];
            ee[c] = e[0];
            el[c] = e[2] & ~m_pend[c];
        end
        check_val({tag, ".clk_out"}, 32'(clk_out), 32'(eo));
        check_val({tag, ".clk_en"}, 32'(clk_en), 32'(ee));
        check_val({tag, ".locked"}, 32'(locked), 32'(el));
    endtask

    task automatic do_cycle(input bit we, input int ch, input int dv, input int ph, input bit sy);
        check_outputs("cyc");
        cfg_we = we;
        cfg_ch = CH_W'(ch);
        cfg_div = CNT_W'(dv);
        cfg_phase = CNT_W'(ph);
        sync_in = sy;
        #1;
        check_val("cfg_ready", 32'(cfg_ready), 32'((ch < NUM_CH) && !m_pend[ch]));
        @(posedge clk);
        model_tick(we, ch, dv, ph, sy);
        @(negedge clk);
        cfg_we = 1'b0;
        sync_in = 1'b0;
    endtask

    initial begin
        bit we, sy;
        int ch, dv, ph;
        repeat (3) @(negedge clk);
        model_reset();
        check_val("rst.clk_out", 32'(clk_out), 32'h0);
        check_val("rst.clk_en", 32'(clk_en), 32'h0);
        check_val("rst.locked", 32'(locked), 32'h0);
        rst = 1'b0;
        for (int i = 0; i < N_CYC; i++) begin
            we = 0; sy = 0; ch = 0; dv = 0; ph = 0;
            case (i)
                2:  begin we = 1; ch = 1; dv = 5; ph = 0; end  // ch1 at cnt=1
                3:  begin we = 1; ch = 1; dv = 9; ph = 2; end  // dropped: ch1 pending
                10: begin we = 1; ch = 2; dv = 1; ph = 0; end  // clamps to 2
                12: begin we = 1; ch = 0; dv = 6; ph = 3; end
                default: begin
                    if (i >= 40) begin
                        we = ($urandom_range(0, 5) == 0);
                        ch = $urandom_range(0, NUM_CH - 1);
                        dv = $urandom_range(0, 9);
                        ph = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 4);
`ifdef CLK_DIV_SYNC_EN
                        sy = ($urandom_range(0, 60) == 0);
`endif
                    end
                end
            endcase
            if (i == 1500) begin
                // Asynchronous reset landing mid-cycle
                #2 rst = 1'b1;
                #1;
                check_val("arst.clk_out", 32'(clk_out), 32'h0);
                check_val("arst.clk_en", 32'(clk_en), 32'h0);
                check_val("arst.locked", 32'(locked), 32'h0);
                @(negedge clk);
                model_reset();
                rst = 1'b0;
            end
            do_cycle(we, ch, dv, ph, sy);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
